hill_cipher_decrypt: RTL and testbench

Hill-cipher decryption engine for 3-letter blocks: P = K⁻¹ · C (mod 26). It is the receive-side counterpart of the team's Hill encryption block and uses the same key-load and text-load write ports and the same character mapping. On `start` it inverts the stored 3x3 key modulo 26 (cofactors, determinant, modular inverse, adjugate) and multiplies the inverse by the ciphertext vector. It then streams three uppercase ASCII plaintext characters, or flags `err` when the key is not invertible.

---
 rtl/hill_pkg.sv | 40 ++++
 rtl/hill_cipher_decrypt_if.sv | 29 ++
 rtl/hill_mod26_inv.sv | 28 ++
 rtl/hill_cipher_decrypt.sv | 221 ++++++++++++++++++++++
 tb/tb_hill_cipher_decrypt.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hill_pkg.sv
// Shared types, constants and helpers for the Hill-cipher blocks.
// Values stored in the register files are always already reduced mod 26.
package hill_pkg;

  localparam int MOD        = 26;
  localparam int BLOCK_SIZE = 3;

  localparam logic [7:0]  ASCII_UPPER_A = 8'd65;
  localparam logic [7:0]  ASCII_LOWER_A = 8'd97;
  localparam logic [11:0] MAC_BIAS      = 12'd676;

  typedef logic [4:0] res_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COF,
    ST_DET,
    ST_INV,
    ST_ADJ,
    ST_MUL,
    ST_OUT
  } state_e;

  function automatic res_t mod26(input logic [11:0] x);
    return res_t'(x % 12'(MOD));
  endfunction

  // Letters of either case map to 0..25; anything else maps to 0.
  function automatic res_t char_to_num(input logic [7:0] ch);
    res_t n;
    n = '0;
    if (ch >= ASCII_UPPER_A && ch <= ASCII_UPPER_A + 8'd25) begin
      n = res_t'(ch - ASCII_UPPER_A);
    end else if (ch >= ASCII_LOWER_A && ch <= ASCII_LOWER_A + 8'd25) begin
      n = res_t'(ch - ASCII_LOWER_A);
    end
    return n;
  endfunction

endpackage

// File: rtl/hill_cipher_decrypt_if.sv
// Load/start/result bundle of the Hill decryption engine.
// The master drives key, ciphertext and start; the slave returns plaintext.
interface hill_cipher_decrypt_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  start;
  logic [DATA_WIDTH-1:0] key_data;
  logic [3:0]            key_addr;
  logic                  key_wen;
  logic [DATA_WIDTH-1:0] text_in;
  logic [1:0]            text_in_addr;
  logic                  text_in_wen;
  logic [DATA_WIDTH-1:0] text_out;
  logic                  text_out_valid;
  logic                  done;
  logic                  err;

  modport master (
    output start, key_data, key_addr, key_wen, text_in, text_in_addr, text_in_wen,
    input  text_out, text_out_valid, done, err
  );

  modport slave (
    input  start, key_data, key_addr, key_wen, text_in, text_in_addr, text_in_wen,
    output text_out, text_out_valid, done, err
  );

endinterface

// File: rtl/hill_mod26_inv.sv
// Combinational modular inverse mod 26; valid is low when det shares a factor with 26.
module hill_mod26_inv (
  input  logic [4:0] det,
  output logic [4:0] inv,
  output logic       valid
);

  always_comb begin
    inv   = '0;
    valid = 1'b1;
    case (det)
      5'd1:    inv = 5'd1;
      5'd3:    inv = 5'd9;
      5'd9:    inv = 5'd3;
      5'd5:    inv = 5'd21;
      5'd21:   inv = 5'd5;
      5'd7:    inv = 5'd15;
      5'd15:   inv = 5'd7;
      5'd11:   inv = 5'd19;
      5'd19:   inv = 5'd11;
      5'd17:   inv = 5'd23;
      5'd23:   inv = 5'd17;
      5'd25:   inv = 5'd25;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/hill_cipher_decrypt.sv
// Hill-cipher decryption of one 3-letter block: inverts the key mod 26 and
// multiplies it by the ciphertext using a single time-shared multiply-accumulate.
module hill_cipher_decrypt #(
  parameter int BLOCK_SIZE = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hill_cipher_decrypt_if.slave bus
);

  import hill_pkg::*;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  res_t key_q   [9];
  res_t key_d   [9];
  res_t cof_q   [9];
  res_t cof_d   [9];
  res_t kinv_q  [9];
  res_t kinv_d  [9];
  res_t text_q  [BLOCK_SIZE];
  res_t text_d  [BLOCK_SIZE];
  res_t plain_q [BLOCK_SIZE];
  res_t plain_d [BLOCK_SIZE];

  res_t det_q, det_d, det_inv_q, det_inv_d;

  logic [DATA_WIDTH-1:0] text_out_q, text_out_d;
  logic valid_q, valid_d, done_q, done_d, err_q, err_d;

  res_t inv_lut;
  logic inv_ok;

  logic [1:0] row, col, r_lo, r_hi, c_lo, c_hi;
  res_t op_a [3];
  res_t op_b [3];
  res_t sub_a, sub_b;
  logic [11:0] mac_sum;
  res_t mac_res;

  function automatic logic [3:0] rc(input logic [1:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  hill_mod26_inv u_inv (
    .det   (det_q),
    .inv   (inv_lut),
    .valid (inv_ok)
  );

  // Row/column of the current matrix element, plus the two rows/cols of its minor.
  always_comb begin
    row = 2'd0;
    if (cnt_q >= 4'd6) begin
      row = 2'd2;
    end else if (cnt_q >= 4'd3) begin
      row = 2'd1;
    end
    col  = 2'(cnt_q - 4'd3 * 4'(row));
    r_lo = (row == 2'd0) ? 2'd1 : 2'd0;
    r_hi = (row == 2'd2) ? 2'd1 : 2'd2;
    c_lo = (col == 2'd0) ? 2'd1 : 2'd0;
    c_hi = (col == 2'd2) ? 2'd1 : 2'd2;
  end

  // Shared MAC: sum of three products plus 676 minus one product, reduced mod 26.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      op_a[j] = '0;
      op_b[j] = '0;
    end
    sub_a = '0;
    sub_b = '0;
    unique case (state_q)
      ST_COF: begin
        if (row[0] ^ col[0]) begin
          op_a[0] = key_q[rc(r_lo, c_hi)];
          op_b[0] = key_q[rc(r_hi, c_lo)];
          sub_a   = key_q[rc(r_lo, c_lo)];
          sub_b   = key_q[rc(r_hi, c_hi)];
        end else begin
          op_a[0] = key_q[rc(r_lo, c_lo)];
          op_b[0] = key_q[rc(r_hi, c_hi)];
          sub_a   = key_q[rc(r_lo, c_hi)];
          sub_b   = key_q[rc(r_hi, c_lo)];
        end
      end
      ST_DET: begin
        for (int j = 0; j < 3; j++) begin
          op_a[j] = key_q[j];
          op_b[j] = cof_q[j];
        end
      end
      ST_ADJ: begin
        op_a[0] = det_inv_q;
        op_b[0] = cof_q[rc(col, row)];
      end
      ST_MUL: begin
        for (int j = 0; j < BLOCK_SIZE; j++) begin
          op_a[j] = kinv_q[rc(cnt_q[1:0], 2'(j))];
          op_b[j] = text_q[j];
        end
      end
      default: ;
    endcase
    mac_sum = 12'(op_a[0]) * 12'(op_b[0]) + 12'(op_a[1]) * 12'(op_b[1])
            + 12'(op_a[2]) * 12'(op_b[2]) + MAC_BIAS - 12'(sub_a) * 12'(sub_b);
    mac_res = mod26(mac_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_COF;
      ST_COF:  if (cnt_q == 4'd8) state_d = ST_DET;
      ST_DET:  state_d = ST_INV;
      ST_INV:  state_d = inv_ok ? ST_ADJ : ST_IDLE;
      ST_ADJ:  if (cnt_q == 4'd8) state_d = ST_MUL;
      ST_MUL:  if (cnt_q == 4'd2) state_d = ST_OUT;
      ST_OUT:  if (cnt_q == 4'd2) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    key_d      = key_q;
    cof_d      = cof_q;
    kinv_d     = kinv_q;
    text_d     = text_q;
    plain_d    = plain_q;
    det_d      = det_q;
    det_inv_d  = det_inv_q;
    text_out_d = text_out_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_d      = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (bus.key_wen && bus.key_addr < 4'd9) begin
          key_d[bus.key_addr] = mod26(12'(bus.key_data));
        end
        if (bus.text_in_wen && bus.text_in_addr != 2'd3) begin
          text_d[bus.text_in_addr] = char_to_num(bus.text_in[7:0]);
        end
        if (bus.start) begin
          err_d = 1'b0;
        end
      end
      ST_COF: cof_d[cnt_q] = mac_res;
      ST_DET: det_d = mac_res;
      ST_INV: begin
        if (inv_ok) begin
          det_inv_d = inv_lut;
        end else begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      ST_ADJ: kinv_d[cnt_q] = mac_res;
      ST_MUL: plain_d[cnt_q[1:0]] = mac_res;
      ST_OUT: begin
        text_out_d = DATA_WIDTH'(plain_q[cnt_q[1:0]]) + DATA_WIDTH'(ASCII_UPPER_A);
        valid_d    = 1'b1;
        done_d     = (cnt_q == 4'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      det_q      <= '0;
      det_inv_q  <= '0;
      text_out_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        key_q[i]  <= '0;
        cof_q[i]  <= '0;
        kinv_q[i] <= '0;
      end
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        text_q[i]  <= '0;
        plain_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      det_q      <= det_d;
      det_inv_q  <= det_inv_d;
      text_out_q <= text_out_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      key_q      <= key_d;
      cof_q      <= cof_d;
      kinv_q     <= kinv_d;
      text_q     <= text_d;
      plain_q    <= plain_d;
    end
  end

  assign bus.text_out       = text_out_q;
  assign bus.text_out_valid = valid_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_hill_cipher_decrypt.sv
// Scoreboard bench for hill_cipher_decrypt: a brute-force mod-26 solver predicts
// each block, and a negedge monitor checks characters, done/err and their cycle.
module tb_hill_cipher_decrypt;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hill_cipher_decrypt_if #(.DATA_WIDTH(8)) bus ();

  hill_cipher_decrypt #(.BLOCK_SIZE(3), .DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    int          ch;
    bit          last;
    int unsigned at_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          n_compared = 0;
  int          n_failed   = 0;
  int unsigned edge_cnt   = 0;
  int unsigned e0;

  int         key_m   [9];
  int         text_m  [3];
  int         plain_m [3];
  logic [7:0] key_stim [9];
  logic [7:0] txt_stim [3];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  function automatic int char_num(input logic [7:0] ch);
    if (ch >= 8'd65 && ch <= 8'd90) return int'(ch) - 65;
    if (ch >= 8'd97 && ch <= 8'd122) return int'(ch) - 97;
    return 0;
  endfunction

  // Reference: key invertible iff det is coprime with 26; plaintext found by exhaustive search of K*P == C.
  task automatic model_block(output bit ok);
    int det;
    bit found;
    det = key_m[0] * (key_m[4] * key_m[8] - key_m[5] * key_m[7])
        - key_m[1] * (key_m[3] * key_m[8] - key_m[5] * key_m[6])
        + key_m[2] * (key_m[3] * key_m[7] - key_m[4] * key_m[6]);
    det = ((det % 26) + 26) % 26;
    found = 1'b0;
    for (int i = 0; i < 3; i++) plain_m[i] = 0;
    if (det % 2 != 0 && det != 13) begin
      for (int a = 0; a < 26; a++) begin
        for (int b = 0; b < 26; b++) begin
          for (int c = 0; c < 26; c++) begin
            if (!found &&
                (key_m[0] * a + key_m[1] * b + key_m[2] * c) % 26 == text_m[0] &&
                (key_m[3] * a + key_m[4] * b + key_m[5] * c) % 26 == text_m[1] &&
                (key_m[6] * a + key_m[7] * b + key_m[8] * c) % 26 == text_m[2]) begin
              found = 1'b1;
              plain_m[0] = a;
              plain_m[1] = b;
              plain_m[2] = c;
            end
          end
        end
      end
    end
    ok = found;
  endtask

  task automatic writeKey();
    for (int i = 0; i < 9; i++) begin
      bus.key_wen  = 1'b1;
      bus.key_addr = 4'(i);
      bus.key_data = key_stim[i];
      key_m[i]     = int'(key_stim[i]) % 26;
      @(negedge clk);
    end
    bus.key_addr = 4'(9 + $urandom_range(0, 6));
    bus.key_data = 8'd7;
    @(negedge clk);
    bus.key_wen = 1'b0;
  endtask

  task automatic writeText();
    for (int i = 0; i < 3; i++) begin
      bus.text_in_wen  = 1'b1;
      bus.text_in_addr = 2'(i);
      bus.text_in      = txt_stim[i];
      text_m[i]        = char_num(txt_stim[i]);
      @(negedge clk);
    end
    bus.text_in_addr = 2'd3;
    bus.text_in      = "Q";
    @(negedge clk);
    bus.text_in_wen = 1'b0;
  endtask

  // Called at a negedge; start is sampled by the next rising edge (E0).
  task automatic applyStimulus(input bit expect_result);
    bit   ok;
    exp_t e;
    model_block(ok);
    bus.start = 1'b1;
    e0 = edge_cnt + 1;
    if (expect_result) begin
      if (ok) begin
        for (int i = 0; i < 3; i++) begin
          e.is_err  = 1'b0;
          e.ch      = plain_m[i] + 65;
          e.last    = (i == 2);
          e.at_edge = e0 + 24 + i;
          exp_q.push_back(e);
        end
      end else begin
        e.is_err  = 1'b1;
        e.ch      = 0;
        e.last    = 1'b1;
        e.at_edge = e0 + 11;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 80) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL drain_timeout: %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every valid or done cycle must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && (bus.text_out_valid === 1'b1 || bus.done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_failed++;
        $display("[TB] FAIL unexpected_output: valid=%0b done=%0b text_out=%0d at edge %0d, required no output",
                 bus.text_out_valid, bus.done, bus.text_out, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err) begin
          checkOutput("err_flag", int'(bus.err), 1);
          checkOutput("err_no_valid", int'(bus.text_out_valid), 0);
          checkOutput("err_done", int'(bus.done), 1);
          checkOutput("err_edge", int'(edge_cnt), int'(e.at_edge));
        end else begin
          checkOutput("char", int'(bus.text_out), e.ch);
          checkOutput("char_valid", int'(bus.text_out_valid), 1);
          checkOutput("char_done", int'(bus.done), int'(e.last));
          checkOutput("char_edge", int'(edge_cnt), int'(e.at_edge));
          checkOutput("char_err_low", int'(bus.err), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start        = 1'b0;
    bus.key_wen      = 1'b0;
    bus.key_addr     = '0;
    bus.key_data     = '0;
    bus.text_in      = '0;
    bus.text_in_addr = '0;
    bus.text_in_wen  = 1'b0;
    rst_n            = 1'b0;
    for (int i = 0; i < 9; i++) key_m[i] = 0;
    for (int i = 0; i < 3; i++) text_m[i] = 0;

    #1;
    checkOutput("reset_text_out", int'(bus.text_out), 0);
    checkOutput("reset_valid", int'(bus.text_out_valid), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_err", int'(bus.err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] GYBNQKURP key, POH -> ACT");
    key_stim = '{8'd6, 8'd24, 8'd1, 8'd13, 8'd16, 8'd10, 8'd20, 8'd17, 8'd15};
    writeKey();
    txt_stim = '{"P", "O", "H"};
    writeText();
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] lowercase fin -> CAT");
    txt_stim = '{"f", "i", "n"};
    writeText();
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] det 2 key -> err");
    key_stim = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    writeKey();
    applyStimulus(1'b1);
    waitDrain();
    repeat (5) @(negedge clk);
    checkOutput("err_held", int'(bus.err), 1);

    $display("[TB] identity key, XYZ, ignored start and key write while busy");
    key_stim = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    writeKey();
    txt_stim = '{"X", "Y", "Z"};
    writeText();
    applyStimulus(1'b1);
    checkOutput("err_cleared_on_start", int'(bus.err), 0);
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.key_wen  = 1'b1;
    bus.key_addr = 4'd0;
    bus.key_data = 8'd5;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.key_wen = 1'b0;
    waitDrain();
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] back-to-back starts at E27");
    key_stim = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    writeKey();
    applyStimulus(1'b1);
    waitDrain();
    key_stim = '{8'd6, 8'd24, 8'd1, 8'd13, 8'd16, 8'd10, 8'd20, 8'd17, 8'd15};
    writeKey();
    txt_stim = '{"P", "O", "H"};
    writeText();
    checkOutput("err_before_restart", int'(bus.err), 1);
    applyStimulus(1'b1);
    checkOutput("err_cleared_b2b", int'(bus.err), 0);
    repeat (26) @(negedge clk);
    applyStimulus(1'b1);
    waitDrain();
    txt_stim = '{"F", "I", "N"};
    writeText();
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] reset in the middle of a block");
    applyStimulus(1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_text_out", int'(bus.text_out), 0);
    checkOutput("midreset_valid", int'(bus.text_out_valid), 0);
    checkOutput("midreset_done", int'(bus.done), 0);
    checkOutput("midreset_err", int'(bus.err), 0);
    for (int i = 0; i < 9; i++) key_m[i] = 0;
    for (int i = 0; i < 3; i++) text_m[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1);
    waitDrain();

    $display("[TB] randomized blocks");
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 9; i++) key_stim[i] = 8'($urandom_range(0, 255));
      writeKey();
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 3))
          0:       txt_stim[i] = 8'(8'd65 + 8'($urandom_range(0, 25)));
          1:       txt_stim[i] = 8'(8'd97 + 8'($urandom_range(0, 25)));
          2:       txt_stim[i] = 8'($urandom_range(0, 64));
          default: txt_stim[i] = 8'($urandom_range(123, 255));
        endcase
      end
      writeText();
      applyStimulus(1'b1);
      waitDrain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
